// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, ROM fetch and {pc, instr} queue to decode
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_instr,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_instr,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                     misalign_trap,
  output logic [31:0]              misalign_pc
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, RUN, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            pop_raw;
  logic            pop;
  logic            push;
  logic            redir;

  assign imem_addr  = pc;
  assign fifo_count = count;
  assign id_valid   = (count != '0);
  assign id_pc      = id_valid ? mem_pc[rd_ptr]    : 32'h0;
  assign id_instr   = id_valid ? mem_instr[rd_ptr] : 32'h0;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir = redirect_valid & (state != TRAP);
`else
  assign redir = redirect_valid;
`endif

  // Redirect wins over everything: same-cycle push and pop are dropped.
  assign pop_raw = id_valid & id_ready;
  assign pop     = pop_raw & ~redir;
  assign push    = (state == RUN) & fetch_en & ~redirect_valid & ((count < FULL) | pop_raw);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= imem_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
      misalign_pc   <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE:    if (fetch_en)  state <= RUN;
        RUN:     if (!fetch_en) state <= IDLE;
        default: state <= state;
      endcase
      if (redir) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) begin
          state         <= TRAP;
          misalign_trap <= 1'b1;
          misalign_pc   <= redirect_pc;
        end else begin
          pc <= redirect_pc;
        end
`else
        pc <= {redirect_pc[31:2], 2'b00};
`endif
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          pc     <= pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
// Honours FETCH_MISALIGN_TRAP_EN when defined.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, fetch_en, redirect_valid, id_ready, id_valid;
  logic [31:0] redirect_pc, imem_addr, imem_instr, id_pc, id_instr;
  logic [1:0]  fifo_count;
  logic        reset2, fetch_en2, redirect_valid2, id_ready2, id_valid2;
  logic [31:0] redirect_pc2, imem_addr2, imem_instr2, id_pc2, id_instr2;
  logic [1:0]  fifo_count2;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap, misalign_trap2;
  logic [31:0] misalign_pc, misalign_pc2;
`endif

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_instr  = rom(imem_addr);
  assign imem_instr2 = rom(imem_addr2);

  instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .fifo_count(fifo_count)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap), .misalign_pc(misalign_pc)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset2), .fetch_en(fetch_en2), .imem_addr(imem_addr2),
    .imem_instr(imem_instr2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .id_valid(id_valid2), .id_ready(id_ready2), .id_pc(id_pc2), .id_instr(id_instr2),
    .fifo_count(fifo_count2)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap2), .misalign_pc(misalign_pc2)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] m_pc;
  bit          m_run;
  bit          m_trap;
  logic [31:0] m_tpc;
  logic [63:0] sb[$];

  task automatic model_reset();
    m_pc = 32'h0; m_run = 0; m_trap = 0; m_tpc = 32'h0;
    sb.delete();
  endtask

  // Caller drives inputs while clk is low; outputs are checked, model advanced, one edge taken.
  task automatic cycle();
    bit pop, push;
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("fifo_count", fifo_count, sb.size());
    check_eq("id_valid", id_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      check_eq("id_pc", id_pc, sb[0][63:32]);
      check_eq("id_instr", id_instr, sb[0][31:0]);
    end else begin
      check_eq("id_pc_idle", id_pc, 0);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("misalign_trap", misalign_trap, m_trap);
    check_eq("misalign_pc", misalign_pc, m_tpc);
`endif
    pop = (sb.size() != 0) && id_ready;
    if (redirect_valid && !m_trap) begin
      sb.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        m_trap = 1; m_tpc = redirect_pc;
      end else m_pc = redirect_pc;
`else
      m_pc = {redirect_pc[31:2], 2'b00};
`endif
    end else begin
      push = m_run && !m_trap && fetch_en && !redirect_valid && (sb.size() < 2 || pop);
      if (pop) void'(sb.pop_front());
      if (push) begin
        sb.push_back({m_pc, rom(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = fetch_en && !m_trap;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", id_valid, 1'b0);
    check_eq("rst_id_pc", id_pc, 32'h0);
    check_eq("rst_id_instr", id_instr, 32'h0);
    check_eq("rst_count", fifo_count, 2'd0);
    reset = 1'b0;
    model_reset();
  endtask

  int n;
  logic [31:0] seen [4];

  initial begin
    fetch_en = 0; redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    reset2 = 1; fetch_en2 = 0; redirect_valid2 = 0; redirect_pc2 = 0; id_ready2 = 1;
    do_reset();

    // streaming
    fetch_en = 1; id_ready = 1;
    repeat (8) cycle();

    // back-pressure then release
    do_reset();
    fetch_en = 1; id_ready = 0;
    repeat (6) cycle();
    check_eq("bp_count", fifo_count, 2'd2);
    check_eq("bp_id_pc", id_pc, 32'h0);
    check_eq("bp_addr", imem_addr, 32'h8);
    id_ready = 1;
    repeat (4) cycle();

    // redirect while full
    id_ready = 0;
    repeat (3) cycle();
    check_eq("pre_redir_count", fifo_count, 2'd2);
    redirect_valid = 1; redirect_pc = 32'h40; id_ready = 1;
    cycle();
    redirect_valid = 0;
    check_eq("redir_count", fifo_count, 2'd0);
    check_eq("redir_valid", id_valid, 1'b0);
    check_eq("redir_addr", imem_addr, 32'h40);
    cycle();
    check_eq("redir_id_pc", id_pc, 32'h40);
    repeat (3) cycle();

    // drain with fetch disabled
    fetch_en = 0;
    repeat (4) cycle();
    check_eq("drain_count", fifo_count, 2'd0);
    check_eq("drain_addr", imem_addr, m_pc);

    // async reset between edges with a full queue
    fetch_en = 1; id_ready = 0;
    repeat (4) cycle();
    check_eq("pre_rst_count", fifo_count, 2'd2);
    #1 reset = 1'b1;
    #1;
    check_eq("arst_valid", id_valid, 1'b0);
    check_eq("arst_addr", imem_addr, 32'h0);
    check_eq("arst_count", fifo_count, 2'd0);
    reset = 1'b0;
    model_reset();
    id_ready = 1;
    repeat (5) cycle();

    // random traffic
    for (int i = 0; i < 60; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      fetch_en = ($urandom_range(0, 7) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc = $urandom & 32'h0000_FFFC;
      cycle();
    end
    redirect_valid = 0; fetch_en = 1; id_ready = 1;
    repeat (3) cycle();

    // misaligned redirect
    redirect_valid = 1; redirect_pc = 32'h42;
    cycle();
    redirect_valid = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("trap_flag", misalign_trap, 1'b1);
    check_eq("trap_pc", misalign_pc, 32'h42);
    check_eq("trap_valid", id_valid, 1'b0);
    check_eq("trap_addr", imem_addr, m_pc);
    redirect_valid = 1; redirect_pc = 32'h100;
    repeat (3) cycle();
    redirect_valid = 0;
`else
    check_eq("misalign_addr", imem_addr, 32'h40);
    repeat (3) cycle();
`endif

    // PC wrap with RESET_PC=0xFFFF_FFF8
    @(negedge clk);
    reset2 = 0; fetch_en2 = 1;
    n = 0;
    for (int i = 0; i < 10 && n < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (id_valid2) begin
        seen[n] = id_pc2;
        if (n == 0) check_eq("wrap_instr0", id_instr2, 32'hA000_0000 + 32'h3FFF_FFFE);
        n++;
      end
    end
    check_eq("wrap_n", n, 4);
    check_eq("wrap_pc0", seen[0], 32'hFFFF_FFF8);
    check_eq("wrap_pc1", seen[1], 32'hFFFF_FFFC);
    check_eq("wrap_pc2", seen[2], 32'h0000_0000);
    check_eq("wrap_pc3", seen[3], 32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
